dcache_dm: RTL

- Direct-mapped, write-through, no-write-allocate data cache between the MIPS pipeline MEM stage and a word-wide backing memory.
- It replaces the flat preloaded data RAM as the CPU-side data store.
- Cache geometry is parameterised. Byte-enabled stores are supported.
- Misses refill a full line through a req/ack memory handshake, and the pipeline is held with a stall output while this happens.

---
 rtl/dcache_dm.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-through no-write-allocate data cache with req/ack line refill
module dcache_dm #(
  parameter int SETS = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              wr,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - 2 - OW - IW;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [SETS-1:0] valid;
  logic [TW-1:0] tags [SETS];
  logic [31:0] data [SETS*LINE_WORDS];
  logic [OW-1:0] beat, word, m_word;
  logic [IW-1:0] index, m_index;
  logic [TW-1:0] tag, m_tag;
  logic hit, m_hit, last;
  logic [31:0] merged;
  logic unused_ok;
  // CPU-side fields come from the live address; the in-flight transaction is tracked entirely by mem_addr
  assign word      = addr[2+:OW];
  assign index     = addr[2+OW+:IW];
  assign tag       = addr[ADDR_W-1-:TW];
  assign m_word    = mem_addr[2+:OW];
  assign m_index   = mem_addr[2+OW+:IW];
  assign m_tag     = mem_addr[ADDR_W-1-:TW];
  assign hit       = valid[index] && tags[index] == tag;
  assign m_hit     = valid[m_index] && tags[m_index] == m_tag;
  assign last      = beat == OW'(LINE_WORDS - 1);
  assign rdata     = (re && !wr && hit) ? data[{index, word}] : '0;
  assign unused_ok = ^addr[1:0];
  // byte-enable merge of the held store into the resident word
  always_comb begin
    merged = data[{m_index, m_word}];
    for (int b = 0; b < 4; b++)
      merged[8*b+:8] = mem_be[b] ? mem_wdata[8*b+:8] : merged[8*b+:8];
  end
  // next-state and pipeline hold
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        stall    = wr || (re && !hit);
        state_nx = wr ? WRITE : (re && !hit) ? REFILL : IDLE;
      end
      REFILL: begin
        stall    = 1'b1;
        state_nx = (mem_ack && last) ? DONE : REFILL;
      end
      WRITE: begin
        stall    = 1'b1;
        state_nx = mem_ack ? DONE : WRITE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // control state, valid bits and the registered memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      beat      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (wr) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata;
            mem_be    <= be;
          end else if (re && !hit) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {addr[ADDR_W-1:2+OW], {(OW+2){1'b0}}};
            mem_be   <= 4'hf;
            beat     <= '0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (last) begin
              mem_req        <= 1'b0;
              valid[m_index] <= 1'b1;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(4);
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  // tag and data arrays: refill beats, and write-through hits update the cached copy
  always_ff @(posedge clk) begin
    if (!reset && state == REFILL && mem_ack) begin
      data[{m_index, beat}] <= mem_rdata;
      if (last) tags[m_index] <= m_tag;
    end else if (!reset && state == WRITE && mem_ack && m_hit) begin
      data[{m_index, m_word}] <= merged;
    end
  end
endmodule
